// File: rtl/hazard_ctrl_pkg.sv
// Shared core defines: opcode constants and register-file geometry used across
// the pipeline control blocks.
package hazard_ctrl_pkg;

    localparam int REG_AW = 5;
    localparam int OPC_W  = 7;

    localparam logic [OPC_W-1:0] OPC_LOAD   = 7'b0000011;
    localparam logic [OPC_W-1:0] OPC_ALI    = 7'b0010011;  // addi x0,x0,0 is the pipeline NOP
    localparam logic [OPC_W-1:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [OPC_W-1:0] OPC_STORE  = 7'b0100011;
    localparam logic [OPC_W-1:0] OPC_ALR    = 7'b0110011;
    localparam logic [OPC_W-1:0] OPC_LUI    = 7'b0110111;
    localparam logic [OPC_W-1:0] OPC_BRANCH = 7'b1100011;
    localparam logic [OPC_W-1:0] OPC_JALR   = 7'b1100111;
    localparam logic [OPC_W-1:0] OPC_JAL    = 7'b1101111;

endpackage

// File: rtl/hazard_ctrl_if.sv
// ID/EX hazard-detection inputs and pipeline hold/flush controls, bundled
// between the datapath (master) and the hazard controller (slave).
interface hazard_ctrl_if;
    import hazard_ctrl_pkg::*;

    logic [REG_AW-1:0] id_rs1_addr;
    logic [REG_AW-1:0] id_rs2_addr;
    logic              id_rs1_used;
    logic              id_rs2_used;
    logic [OPC_W-1:0]  ex_opcode;
    logic [REG_AW-1:0] ex_rd_addr;
    logic              ex_jump_en;
    logic              jump_hold;
    logic              bubble_hold;
    logic              pc_stall;
    logic              if_id_stall;

    modport master (
        output id_rs1_addr, id_rs2_addr, id_rs1_used, id_rs2_used,
        output ex_opcode, ex_rd_addr, ex_jump_en,
        input  jump_hold, bubble_hold, pc_stall, if_id_stall
    );

    modport slave (
        input  id_rs1_addr, id_rs2_addr, id_rs1_used, id_rs2_used,
        input  ex_opcode, ex_rd_addr, ex_jump_en,
        output jump_hold, bubble_hold, pc_stall, if_id_stall
    );

endinterface

// File: rtl/hazard_ctrl_sat_cnt.sv
// Event counter that sticks at all-ones instead of wrapping.
module sat_cnt #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         inc,
    output logic [W-1:0] count
);

    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
        end else if (inc && (count != '1)) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/hazard_ctrl.sv
// Load-use bubble insertion and taken-jump flush control for the IF/ID and
// ID/EX registers, with saturating stall/flush performance counters.
module hazard_ctrl
    import hazard_ctrl_pkg::*;
#(
    parameter int FLUSH_CYCLES = 2,
    parameter int CNT_W        = 32
) (
    input  logic             clk,
    input  logic             rst,
    hazard_ctrl_if.slave     hz,
    output logic [CNT_W-1:0] stall_count,
    output logic [CNT_W-1:0] flush_count
);

    typedef enum logic {
        S_IDLE  = 1'b0,
        S_FLUSH = 1'b1
    } state_t;

    localparam logic [2:0] FLUSH_RELOAD = 3'(FLUSH_CYCLES - 1);

    state_t     state_q, state_d;
    logic [2:0] flush_left_q, flush_left_d;
    logic       lu;
    logic       jump_hold_c, bubble_c;

    // x0 is never a real producer, so a load to x0 cannot create a hazard
    assign lu = (hz.ex_opcode == OPC_LOAD) && (hz.ex_rd_addr != '0) &&
                ((hz.id_rs1_used && (hz.id_rs1_addr == hz.ex_rd_addr)) ||
                 (hz.id_rs2_used && (hz.id_rs2_addr == hz.ex_rd_addr)));

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            flush_left_q <= '0;
        end else begin
            state_q      <= state_d;
            flush_left_q <= flush_left_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        flush_left_d = flush_left_q;
        jump_hold_c  = 1'b0;
        bubble_c     = 1'b0;

        case (state_q)
            S_IDLE: begin
                jump_hold_c = hz.ex_jump_en;
                bubble_c    = !hz.ex_jump_en && lu;
                if (hz.ex_jump_en && (FLUSH_CYCLES > 1)) begin
                    state_d      = S_FLUSH;
                    flush_left_d = FLUSH_RELOAD;
                end
            end
            S_FLUSH: begin
                // ID is being discarded, so a load-use match here is moot
                jump_hold_c = 1'b1;
                if (hz.ex_jump_en) begin
                    flush_left_d = FLUSH_RELOAD;
                end else if (flush_left_q == 3'd1) begin
                    state_d      = S_IDLE;
                    flush_left_d = '0;
                end else begin
                    flush_left_d = flush_left_q - 3'd1;
                end
            end
            default: begin
                state_d      = S_IDLE;
                flush_left_d = '0;
            end
        endcase

        if (rst) begin
            jump_hold_c = 1'b0;
            bubble_c    = 1'b0;
        end
    end

    assign hz.jump_hold   = jump_hold_c;
    assign hz.bubble_hold = bubble_c;
    assign hz.pc_stall    = bubble_c;
    assign hz.if_id_stall = bubble_c;

    sat_cnt #(.W(CNT_W)) u_stall_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (bubble_c),
        .count (stall_count)
    );

    sat_cnt #(.W(CNT_W)) u_flush_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (hz.ex_jump_en),
        .count (flush_count)
    );

endmodule
